// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock, streaming back-to-back words with no gap.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned           CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               last_bit;
  logic               accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The first bit is registered straight into ser_out at accept, so the shift
  // register only ever holds the bits still to come (already shifted by one).
  always_comb begin
    last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    din_ready = (state_q == IDLE) || last_bit;
    accept    = din_valid && din_ready;

    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;

    if (accept) begin
      state_d     = SHIFT;
      cnt_d       = '0;
      sreg_d      = shift_one(din);
      ser_out_d   = first_bit(din);
      ser_valid_d = 1'b1;
    end else if (last_bit) begin
      state_d     = IDLE;
      cnt_d       = '0;
      sreg_d      = '0;
      ser_out_d   = 1'b0;
      ser_valid_d = 1'b0;
    end else if (state_q == SHIFT) begin
      cnt_d     = cnt_q + 1'b1;
      sreg_d    = shift_one(sreg_q);
      ser_out_d = first_bit(sreg_q);
    end

    frame_done_d = (state_d == SHIFT) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus;
// expected bits are queued at accept and popped as each bit appears.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy_m, out_m, val_m, done_m, busy_m;
  logic         rdy_l, out_l, val_l, done_l, busy_l;

  exp_bit_t     q_m[$];
  exp_bit_t     q_l[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .ser_out(out_m), .ser_valid(val_m), .frame_done(done_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .ser_out(out_l), .ser_valid(val_l), .frame_done(done_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mon_one(input string tag, inout exp_bit_t q[$],
                         input logic o, input logic v, input logic d, input logic b);
    exp_bit_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, " ser_valid"}, 32'(v), 32'd1);
      check({tag, " ser_out"}, 32'(o), 32'(e.b));
      check({tag, " frame_done"}, 32'(d), 32'(e.last));
      check({tag, " busy"}, 32'(b), 32'd1);
    end else begin
      check({tag, " idle ser_valid"}, 32'(v), 32'd0);
      check({tag, " idle ser_out"}, 32'(o), 32'd0);
      check({tag, " idle frame_done"}, 32'(d), 32'd0);
      check({tag, " idle busy"}, 32'(b), 32'd0);
    end
  endtask

  // One clock: drive inputs (just after negedge), check ready, clock, update
  // the expectation queues, then sample outputs at the next negedge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    logic acc;
    rst = r; din_valid = v; din = d;
    #1;
    if (!r) begin
      check("msb din_ready", 32'(rdy_m), 32'(q_m.size() == 0));
      check("lsb din_ready", 32'(rdy_l), 32'(q_l.size() == 0));
    end
    acc = !r && v && (q_m.size() == 0);
    @(posedge clk);
    if (r) begin
      q_m.delete();
      q_l.delete();
    end else if (acc) begin
      for (int unsigned k = 0; k < W; k++) begin
        q_m.push_back('{b: d[W-1-k], last: (k == W - 1)});
        q_l.push_back('{b: d[k],     last: (k == W - 1)});
      end
    end
    @(negedge clk);
    mon_one("msb", q_m, out_m, val_m, done_m, busy_m);
    mon_one("lsb", q_l, out_l, val_l, done_l, busy_l);
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0;
    @(posedge clk);
    @(negedge clk);
    // Reset held for 3 cycles total, then release.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b0, '0);

    // Single frame 8'hB4, then return to idle.
    step(1'b0, 1'b1, 8'hB4);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0);

    // Held valid: 8'hFF then 8'h00 stream back to back.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0);

    // Pulse on the 3rd bit of a frame must be ignored.
    step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);

    // Reset while the 4th bit is out drops the frame; new word right after.
    step(1'b0, 1'b1, 8'h96);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, '0);

    // Random traffic with sparse valid.
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), W'($urandom));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
